// File: rtl/prefix_emit_pkg.sv
// Shared x86 legacy-prefix decode constants, types and helpers used by the
// prefix encoder and the prefix detector.
package prefix_emit_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SEG_W  = 3;
    localparam int unsigned WIN_W  = 24;
    localparam int unsigned PCNT_W = 2;

    localparam logic [BYTE_W-1:0] PFX_REP  = 8'hF3;
    localparam logic [BYTE_W-1:0] PFX_OPSZ = 8'h66;
    localparam logic [BYTE_W-1:0] PFX_ES   = 8'h26;
    localparam logic [BYTE_W-1:0] PFX_CS   = 8'h2E;
    localparam logic [BYTE_W-1:0] PFX_SS   = 8'h36;
    localparam logic [BYTE_W-1:0] PFX_DS   = 8'h3E;
    localparam logic [BYTE_W-1:0] PFX_FS   = 8'h64;
    localparam logic [BYTE_W-1:0] PFX_GS   = 8'h65;

    typedef enum logic [SEG_W-1:0] {
        SEG_NONE = 3'd0,
        SEG_ES   = 3'd1,
        SEG_CS   = 3'd2,
        SEG_SS   = 3'd3,
        SEG_DS   = 3'd4,
        SEG_FS   = 3'd5,
        SEG_GS   = 3'd6,
        SEG_RSVD = 3'd7
    } seg_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REP  = 3'd1,
        ST_SEG  = 3'd2,
        ST_OPSZ = 3'd3,
        ST_OPC  = 3'd4
    } state_e;

    typedef struct packed {
        logic              rep;
        seg_e              seg;
        logic              opsize;
        logic [BYTE_W-1:0] opcode;
    } desc_t;

    function automatic logic seg_present(seg_e s);
        return (s != SEG_NONE) && (s != SEG_RSVD);
    endfunction

    function automatic logic [BYTE_W-1:0] seg_byte(seg_e s);
        logic [BYTE_W-1:0] b;
        case (s)
            SEG_ES:  b = PFX_ES;
            SEG_CS:  b = PFX_CS;
            SEG_SS:  b = PFX_SS;
            SEG_DS:  b = PFX_DS;
            SEG_FS:  b = PFX_FS;
            SEG_GS:  b = PFX_GS;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Canonical emission order is REP, SEG, OPSZ, OPC; skip absent prefixes.
    function automatic state_e next_after(state_e st, logic has_seg, logic has_opsz);
        state_e n;
        case (st)
            ST_REP:  n = has_seg ? ST_SEG : (has_opsz ? ST_OPSZ : ST_OPC);
            ST_SEG:  n = has_opsz ? ST_OPSZ : ST_OPC;
            default: n = ST_OPC;
        endcase
        return n;
    endfunction

    function automatic logic [BYTE_W-1:0] emit_byte(state_e st, seg_e s,
                                                     logic [BYTE_W-1:0] opcode);
        logic [BYTE_W-1:0] b;
        case (st)
            ST_REP:  b = PFX_REP;
            ST_SEG:  b = seg_byte(s);
            ST_OPSZ: b = PFX_OPSZ;
            ST_OPC:  b = opcode;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/prefix_win_pack.sv
// Combinational packing of a descriptor into the left-justified 3-byte decode
// window, prefix count and operand-size flag.
module prefix_win_pack
    import prefix_emit_pkg::*;
(
    input  desc_t              desc,
    output logic [WIN_W-1:0]   win_c,
    output logic [PCNT_W-1:0]  pcnt_c,
    output logic               size_c
);

    logic                   has_seg;
    logic [WIN_W+BYTE_W-1:0] seq;

    assign has_seg = seg_present(desc.seg);

    // Prepend prefixes in reverse order so the first emitted byte ends up on top.
    always_comb begin
        seq = {desc.opcode, 24'h000000};
        if (desc.opsize) seq = {PFX_OPSZ, seq[WIN_W+BYTE_W-1:BYTE_W]};
        if (has_seg)     seq = {seg_byte(desc.seg), seq[WIN_W+BYTE_W-1:BYTE_W]};
        if (desc.rep)    seq = {PFX_REP, seq[WIN_W+BYTE_W-1:BYTE_W]};
    end

    assign win_c  = seq[WIN_W+BYTE_W-1:BYTE_W];
    assign pcnt_c = PCNT_W'(desc.rep) + PCNT_W'(has_seg) + PCNT_W'(desc.opsize);
    assign size_c = desc.opsize;

endmodule

// File: rtl/prefix_emit.sv
// Byte-serial x86 legacy-prefix encoder: accepts one descriptor, emits its
// prefixes then opcode one byte per handshake, and presents the decode window.
module prefix_emit
    import prefix_emit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rep,
    input  logic [SEG_W-1:0]  in_seg,
    input  logic              in_opsize,
    input  logic [BYTE_W-1:0] in_opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last,
    output logic [WIN_W-1:0]  out_win,
    output logic [PCNT_W-1:0] out_pcnt,
    output logic              out_size,
    output logic              err_seg
);

    state_e            state;
    seg_e              seg_q;
    logic              opsize_q;
    logic [BYTE_W-1:0] opcode_q;

    desc_t             in_desc;
    logic [WIN_W-1:0]  win_c;
    logic [PCNT_W-1:0] pcnt_c;
    logic              size_c;
    state_e            first_st_c;
    state_e            next_st_c;

    assign in_desc = '{rep: in_rep, seg: seg_e'(in_seg), opsize: in_opsize, opcode: in_opcode};

    prefix_win_pack u_pack (
        .desc   (in_desc),
        .win_c  (win_c),
        .pcnt_c (pcnt_c),
        .size_c (size_c)
    );

    assign first_st_c = in_rep ? ST_REP
                               : next_after(ST_REP, seg_present(in_desc.seg), in_opsize);
    assign next_st_c  = next_after(state, seg_present(seg_q), opsize_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            seg_q     <= SEG_NONE;
            opsize_q  <= 1'b0;
            opcode_q  <= 8'h00;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_last  <= 1'b0;
            out_win   <= 24'h000000;
            out_pcnt  <= 2'd0;
            out_size  <= 1'b0;
            err_seg   <= 1'b0;
        end else begin
            err_seg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        seg_q     <= in_desc.seg;
                        opsize_q  <= in_opsize;
                        opcode_q  <= in_opcode;
                        state     <= first_st_c;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_byte  <= emit_byte(first_st_c, in_desc.seg, in_opcode);
                        out_last  <= (first_st_c == ST_OPC);
                        out_win   <= win_c;
                        out_pcnt  <= pcnt_c;
                        out_size  <= size_c;
                        err_seg   <= (in_desc.seg == SEG_RSVD);
                    end
                end
                ST_OPC: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    // Prefix byte held until the consumer takes it.
                    if (out_ready) begin
                        state    <= next_st_c;
                        out_byte <= emit_byte(next_st_c, seg_q, opcode_q);
                        out_last <= (next_st_c == ST_OPC);
                    end
                end
            endcase
        end
    end

endmodule
